// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue side of the datapath ALU. Accepts a decoded operation over a
// valid/ready handshake, translates alu_op/funct into the ALU's 3-bit
// select code, holds X/Y/SEL stable for a per-operation number of cycles
// (so MUL/DIV can be timed as multicycle paths), then captures R/Z_flag
// into a writeback register offered over a second valid/ready handshake.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid / in_ready   operation handshake (in_ready high only in IDLE)
//   alu_op, funct         operation encoding (alu_op=10 decodes funct)
//   rs_val, rt_val        operands
//   rd_addr               destination register
//   X, Y, SEL             registered ALU inputs
//   R, Z_flag             ALU result and zero flag
//   out_valid / out_ready result handshake (out_valid high only in HOLD)
//   result, zero, wb_addr captured writeback fields
//   illegal               operation was undecodable, result forced to 0
//   div_zero              DIV with rt_val==0, result forced to all ones
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [4:0]  rd_addr,
    output logic [31:0] X,
    output logic [31:0] Y,
    output logic [2:0]  SEL,
    input  logic [31:0] R,
    input  logic        Z_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic [4:0]  wb_addr,
    output logic        illegal,
    output logic        div_zero
);

    localparam int MaxHold = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CntW    = (MaxHold < 2) ? 1 : $clog2(MaxHold);

    localparam logic [2:0] SelAdd = 3'd0;
    localparam logic [2:0] SelSub = 3'd1;
    localparam logic [2:0] SelAnd = 3'd2;
    localparam logic [2:0] SelOr  = 3'd3;
    localparam logic [2:0] SelSlt = 3'd4;
    localparam logic [2:0] SelNop = 3'd5;
    localparam logic [2:0] SelMul = 3'd6;
    localparam logic [2:0] SelDiv = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       x_q, x_d;
    logic [31:0]       y_q, y_d;
    logic [2:0]        sel_q, sel_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [4:0]        rdLatch_q, rdLatch_d;
    logic [31:0]       result_q, result_d;
    logic              zero_q, zero_d;
    logic [4:0]        wbAddr_q, wbAddr_d;
    logic              illegal_q, illegal_d;
    logic              divZero_q, divZero_d;

    logic [2:0]        decSel;
    logic              decIllegal;
    logic              decDivZero;
    logic [CntW-1:0]   holdLoad;

    // Translate alu_op/funct into the ALU select code. Anything that does
    // not map to one of the eight ALU functions is flagged illegal; a DIV
    // whose divisor is zero is flagged separately so it never reaches the
    // ALU. holdLoad is the counter preload (hold cycles minus one).
    always_comb begin
        decSel     = SelNop;
        decIllegal = 1'b0;
        case (alu_op)
            2'b00: decSel = SelAdd;
            2'b01: decSel = SelSub;
            2'b10: begin
                case (funct)
                    6'b100000: decSel = SelAdd;
                    6'b100010: decSel = SelSub;
                    6'b100100: decSel = SelAnd;
                    6'b100101: decSel = SelOr;
                    6'b101010: decSel = SelSlt;
                    6'b000000: decSel = SelNop;
                    6'b011000: decSel = SelMul;
                    6'b011010: decSel = SelDiv;
                    default:   decIllegal = 1'b1;
                endcase
            end
            default: decIllegal = 1'b1;
        endcase

        decDivZero = !decIllegal && (decSel == SelDiv) && (rt_val == 32'd0);

        case (decSel)
            SelMul:  holdLoad = CntW'(MUL_CYCLES - 1);
            SelDiv:  holdLoad = CntW'(DIV_CYCLES - 1);
            default: holdLoad = '0;
        endcase
    end

    // Next-state and datapath update. Every register keeps its value by
    // default, which is what keeps X/Y/SEL frozen through EXEC and the
    // writeback fields frozen through HOLD. Illegal and divide-by-zero
    // operations skip EXEC and land in HOLD with their forced results.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        sel_d     = sel_q;
        count_d   = count_q;
        rdLatch_d = rdLatch_q;
        result_d  = result_q;
        zero_d    = zero_q;
        wbAddr_d  = wbAddr_q;
        illegal_d = illegal_q;
        divZero_d = divZero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d       = rs_val;
                    y_d       = rt_val;
                    rdLatch_d = rd_addr;
                    if (decIllegal) begin
                        sel_d     = SelNop;
                        result_d  = 32'd0;
                        zero_d    = 1'b1;
                        wbAddr_d  = rd_addr;
                        illegal_d = 1'b1;
                        divZero_d = 1'b0;
                        state_d   = HOLD;
                    end else if (decDivZero) begin
                        sel_d     = SelNop;
                        result_d  = 32'hFFFF_FFFF;
                        zero_d    = 1'b0;
                        wbAddr_d  = rd_addr;
                        illegal_d = 1'b0;
                        divZero_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        sel_d   = decSel;
                        count_d = holdLoad;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    result_d  = R;
                    zero_d    = Z_flag;
                    wbAddr_d  = rdLatch_q;
                    illegal_d = 1'b0;
                    divZero_d = 1'b0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    sel_d   = SelNop;
                    state_d = IDLE;
                end
            end
            default: begin
                sel_d   = SelNop;
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset wins over everything and discards any
    // operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= 32'd0;
            y_q       <= 32'd0;
            sel_q     <= SelNop;
            count_q   <= '0;
            rdLatch_q <= 5'd0;
            result_q  <= 32'd0;
            zero_q    <= 1'b0;
            wbAddr_q  <= 5'd0;
            illegal_q <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sel_q     <= sel_d;
            count_q   <= count_d;
            rdLatch_q <= rdLatch_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            wbAddr_q  <= wbAddr_d;
            illegal_q <= illegal_d;
            divZero_q <= divZero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign X         = x_q;
    assign Y         = y_q;
    assign SEL       = sel_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign wb_addr   = wbAddr_q;
    assign illegal   = illegal_q;
    assign div_zero  = divZero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Directed bench for alu_issue_ctrl with default parameters. A small
// combinational ALU model answers the DUT's X/Y/SEL. Inputs change and
// outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  rd_addr;
    logic [31:0] X;
    logic [31:0] Y;
    logic [2:0]  SEL;
    logic [31:0] R;
    logic        Z_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  wb_addr;
    logic        illegal;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .rd_addr   (rd_addr),
        .X         (X),
        .Y         (Y),
        .SEL       (SEL),
        .R         (R),
        .Z_flag    (Z_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .wb_addr   (wb_addr),
        .illegal   (illegal),
        .div_zero  (div_zero)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU standing in for the real datapath
    always_comb begin
        R = 32'd0;
        case (SEL)
            3'd0: R = X + Y;
            3'd1: R = X - Y;
            3'd2: R = X & Y;
            3'd3: R = X | Y;
            3'd4: R = ($signed(X) < $signed(Y)) ? 32'd1 : 32'd0;
            3'd5: R = 32'd0;
            3'd6: R = X * Y;
            3'd7: R = (Y != 32'd0) ? (X / Y) : 32'hFFFF_FFFF;
            default: R = 32'd0;
        endcase
        Z_flag = (R == 32'd0);
    end

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one operation for exactly the accept edge, then withdraw it
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] rd);
        alu_op   = op;
        funct    = fn;
        rs_val   = rs;
        rt_val   = rt;
        rd_addr  = rd;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Consume the held result
    task automatic retire();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        funct     = 6'd0;
        rs_val    = 32'd0;
        rt_val    = 32'd0;
        rd_addr   = 5'd0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sel", 32'(SEL), 32'd5);
        checkOutput("rst_x", X, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_zero", 32'(zero), 32'd0);
        checkOutput("rst_wb", 32'(wb_addr), 32'd0);
        checkOutput("rst_flags", {30'd0, illegal, div_zero}, 32'd0);

        // ADD via funct: one EXEC cycle, valid at accept+2
        applyStimulus(2'b10, 6'b100000, 32'd5, 32'd7, 5'd3);
        checkOutput("add_sel", 32'(SEL), 32'd0);
        checkOutput("add_x", X, 32'd5);
        checkOutput("add_y", Y, 32'd7);
        checkOutput("add_in_ready", 32'(in_ready), 32'd0);
        checkOutput("add_early_valid", 32'(out_valid), 32'd0);
        step();
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_result", result, 32'd12);
        checkOutput("add_zero", 32'(zero), 32'd0);
        checkOutput("add_wb", 32'(wb_addr), 32'd3);
        checkOutput("add_illegal", 32'(illegal), 32'd0);
        retire();
        checkOutput("add_exit_valid", 32'(out_valid), 32'd0);
        checkOutput("add_exit_ready", 32'(in_ready), 32'd1);
        checkOutput("add_exit_sel", 32'(SEL), 32'd5);

        // SUB to zero, result held while consumer stalls; a competing
        // operation offered meanwhile must be ignored
        applyStimulus(2'b01, 6'b000000, 32'h1234, 32'h1234, 5'd9);
        checkOutput("sub_sel", 32'(SEL), 32'd1);
        step();
        alu_op   = 2'b00;
        rs_val   = 32'd1;
        rt_val   = 32'd1;
        rd_addr  = 5'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("sub_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("sub_hold_result", result, 32'd0);
            checkOutput("sub_hold_zero", 32'(zero), 32'd1);
            checkOutput("sub_hold_wb", 32'(wb_addr), 32'd9);
            checkOutput("sub_hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("sub_hold_sel", 32'(SEL), 32'd1);
            step();
        end
        // in_valid still high across the exit edge: no same-cycle accept
        retire();
        checkOutput("sub_exit_ready", 32'(in_ready), 32'd1);
        checkOutput("sub_exit_sel", 32'(SEL), 32'd5);
        checkOutput("sub_exit_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // MUL: SEL=6 for two cycles, valid at accept+3
        applyStimulus(2'b10, 6'b011000, 32'd6, 32'd7, 5'd4);
        checkOutput("mul_c1_sel", 32'(SEL), 32'd6);
        checkOutput("mul_c1_valid", 32'(out_valid), 32'd0);
        step();
        checkOutput("mul_c2_sel", 32'(SEL), 32'd6);
        checkOutput("mul_c2_valid", 32'(out_valid), 32'd0);
        step();
        checkOutput("mul_valid", 32'(out_valid), 32'd1);
        checkOutput("mul_result", result, 32'd42);
        checkOutput("mul_wb", 32'(wb_addr), 32'd4);
        retire();

        // DIV: SEL=7 for four cycles, valid at accept+5
        applyStimulus(2'b10, 6'b011010, 32'd100, 32'd7, 5'd5);
        checkOutput("div_c1_sel", 32'(SEL), 32'd7);
        checkOutput("div_c1_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("div_exec_sel", 32'(SEL), 32'd7);
            checkOutput("div_exec_valid", 32'(out_valid), 32'd0);
        end
        step();
        checkOutput("div_valid", 32'(out_valid), 32'd1);
        checkOutput("div_result", result, 32'd14);
        checkOutput("div_wb", 32'(wb_addr), 32'd5);
        checkOutput("div_flag", 32'(div_zero), 32'd0);
        retire();

        // DIV by zero: straight to HOLD, SEL never 7
        applyStimulus(2'b10, 6'b011010, 32'd50, 32'd0, 5'd6);
        checkOutput("dz_valid", 32'(out_valid), 32'd1);
        checkOutput("dz_sel", 32'(SEL), 32'd5);
        checkOutput("dz_flag", 32'(div_zero), 32'd1);
        checkOutput("dz_result", result, 32'hFFFF_FFFF);
        checkOutput("dz_zero", 32'(zero), 32'd0);
        checkOutput("dz_illegal", 32'(illegal), 32'd0);
        retire();

        // Illegal alu_op
        applyStimulus(2'b11, 6'b100000, 32'd8, 32'd9, 5'd10);
        checkOutput("ill_op_valid", 32'(out_valid), 32'd1);
        checkOutput("ill_op_flag", 32'(illegal), 32'd1);
        checkOutput("ill_op_result", result, 32'd0);
        checkOutput("ill_op_zero", 32'(zero), 32'd1);
        checkOutput("ill_op_sel", 32'(SEL), 32'd5);
        checkOutput("ill_op_dz", 32'(div_zero), 32'd0);
        retire();

        // Illegal funct
        applyStimulus(2'b10, 6'b111111, 32'd8, 32'd9, 5'd11);
        checkOutput("ill_fn_valid", 32'(out_valid), 32'd1);
        checkOutput("ill_fn_flag", 32'(illegal), 32'd1);
        checkOutput("ill_fn_result", result, 32'd0);
        checkOutput("ill_fn_sel", 32'(SEL), 32'd5);
        retire();

        // Legal ADD afterwards clears the illegal flag
        applyStimulus(2'b00, 6'b000000, 32'd1, 32'd2, 5'd7);
        checkOutput("add2_early_valid", 32'(out_valid), 32'd0);
        step();
        checkOutput("add2_valid", 32'(out_valid), 32'd1);
        checkOutput("add2_result", result, 32'd3);
        checkOutput("add2_illegal", 32'(illegal), 32'd0);
        checkOutput("add2_wb", 32'(wb_addr), 32'd7);
        retire();

        // Reset during the second EXEC cycle of a DIV
        applyStimulus(2'b10, 6'b011010, 32'd100, 32'd7, 5'd12);
        step();
        checkOutput("rdiv_sel", 32'(SEL), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rdiv_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rdiv_valid", 32'(out_valid), 32'd0);
        checkOutput("rdiv_sel_nop", 32'(SEL), 32'd5);
        checkOutput("rdiv_result", result, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("rdiv_no_output", 32'(out_valid), 32'd0);
        end

        // SLT after the reset
        applyStimulus(2'b10, 6'b101010, 32'd3, 32'd9, 5'd8);
        checkOutput("slt_sel", 32'(SEL), 32'd4);
        step();
        checkOutput("slt_valid", 32'(out_valid), 32'd1);
        checkOutput("slt_result", result, 32'd1);
        checkOutput("slt_zero", 32'(zero), 32'd0);
        checkOutput("slt_wb", 32'(wb_addr), 32'd8);
        retire();
        checkOutput("slt_exit_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue side of the datapath ALU. It accepts a decoded operation (alu_op, funct, two operands, destination register) over a valid/ready handshake and translates it into the ALU's 3-bit select code. It holds the ALU's X/Y/SEL inputs stable for a per-operation number of cycles so that long MUL/DIV paths can run as multicycle paths. It then captures the ALU's R and Z_flag into an output register for writeback, held with a valid/ready handshake.

Parameters:
MUL_CYCLES, 2, cycles X/Y/SEL are held before capture for SEL=6 (minimum 1)
DIV_CYCLES, 4, cycles X/Y/SEL are held before capture for SEL=7 (minimum 1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept; high only in IDLE
alu_op  in  2  00=ADD, 01=SUB, 10=decode funct, 11=illegal
funct  in  6  R-type function field
rs_val  in  32  first operand
rt_val  in  32  second operand
rd_addr  in  5  destination register
X  out  32  ALU operand X (registered)
Y  out  32  ALU operand Y (registered)
SEL  out  3  ALU select (registered)
R  in  32  ALU result
Z_flag  in  1  ALU zero flag
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  32  captured result
zero  out  1  captured zero flag
wb_addr  out  5  captured destination
illegal  out  1  op was undecodable; result forced to 0
div_zero  out  1  DIV with rt_val==0; result forced to 32'hFFFFFFFF

Behaviour:
- Reset (synchronous, wins over everything): state=IDLE; X=0, Y=0, SEL=3'd5 (NOP); out_valid=0, result=0, zero=0, wb_addr=0, illegal=0, div_zero=0; counter=0. Reset during EXEC or HOLD discards the operation, and no output appears.
- Decode when alu_op=10, by funct: 100000→0 ADD, 100010→1 SUB, 100100→2 AND, 100101→3 OR, 101010→4 SLT, 000000→5 NOP, 011000→6 MUL, 011010→7 DIV. Any other funct is illegal. alu_op=00→0, 01→1, 11→illegal.
- Hold count per operation: SEL 0–5 → 1 cycle; SEL 6 → MUL_CYCLES; SEL 7 → DIV_CYCLES.
- State machine, states IDLE, EXEC, HOLD:
  - IDLE: in_ready=1. When in_valid=1, register X=rs_val, Y=rt_val, SEL=decoded value, latch rd_addr, load counter=hold−1, and go to EXEC.
  - IDLE, illegal op: SEL=5 and next state is HOLD directly, with result=0, zero=1, illegal=1, div_zero=0.
  - IDLE, DIV with rt_val==0: SEL=7 is not driven (SEL=5). Go to HOLD directly with result=32'hFFFFFFFF, zero=0, div_zero=1, illegal=0.
  - EXEC: in_ready=0 and X/Y/SEL are held constant. If counter≠0, decrement it. If counter==0, capture result=R, zero=Z_flag, wb_addr, illegal=0, div_zero=0, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1, and all output fields stay stable until out_ready=1. On the out_ready edge: out_valid=0, SEL=5, go to IDLE.
- No new acceptance occurs in the same cycle as HOLD→IDLE.
- Latency from the accept edge to out_valid high: 1+hold cycles. ADD is 2 cycles; MUL is 1+MUL_CYCLES. Illegal and div-by-zero ops take 1 cycle.
- X/Y/SEL change only on the accept edge or the HOLD exit edge. They never change during EXEC.
- Arithmetic is owned by the ALU. This block adds no width extension; result is R's 32 bits unmodified.
- in_valid while not in IDLE is ignored. The source must hold its operation until in_ready.
- out_ready while not in HOLD has no effect.

Test Plan:
- ADD: alu_op=10, funct=100000, rs=5, rt=7, rd=3 → SEL=0; out_valid 2 cycles after accept, result=12, zero=0, wb_addr=3.
- SUB to zero (beq): alu_op=01, rs=rt=32'h1234 → SEL=1, result=0, zero=1. Hold out_ready=0 for 5 cycles → out_valid and all fields stable and in_ready=0 throughout.
- MUL/DIV timing with defaults:
  - funct=011000, rs=6, rt=7 → SEL=6 held 2 cycles, result=42 at accept+3.
  - funct=011010, rs=100, rt=7 → SEL=7 held 4 cycles, result=14 at accept+5.
- DIV by zero: funct=011010, rt=0 → SEL never 7; div_zero=1, result=32'hFFFFFFFF, zero=0 at accept+1.
- Illegal: alu_op=11, then alu_op=10 with funct=111111 → illegal=1, result=0, zero=1, SEL stays 5. The next legal ADD completes normally with illegal=0.
- Reset mid-DIV: assert rst on the 2nd EXEC cycle → next cycle state IDLE, in_ready=1, out_valid=0, SEL=5; a following SLT with rs=3, rt=9 gives result=1.
